// File: rtl/pixel_fetcher_if.sv
// Bundle of the pixel fetcher's control, image-store and pixel-stream signals.
// The master modport is the fetcher; the slave modport is its environment.
interface pixel_fetcher_if;
  logic [1:0]  image_select;
  logic        frame_start;
  logic [1:0]  mem_select;
  logic [19:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_data;
  logic        pixel_valid;
  logic [23:0] pixel_rgb;
  logic        pixel_ready;
  logic        frame_done;

  modport master (
    input  image_select,
    input  frame_start,
    input  mem_data,
    input  pixel_ready,
    output mem_select,
    output mem_addr,
    output mem_rd,
    output pixel_valid,
    output pixel_rgb,
    output frame_done
  );

  modport slave (
    output image_select,
    output frame_start,
    output mem_data,
    output pixel_ready,
    input  mem_select,
    input  mem_addr,
    input  mem_rd,
    input  pixel_valid,
    input  pixel_rgb,
    input  frame_done
  );
endinterface

// File: rtl/pixel_fetcher.sv
// Pixel fetcher: reads 3-byte RGB pixels from a byte-wide image store and
// streams them out through a small FIFO with a valid/ready handshake.
module pixel_fetcher #(
  parameter int unsigned Resolution = 640 * 480,
  parameter int unsigned FifoDepth  = 4
) (
  input logic             clk_i,
  input logic             rst_ni,
  pixel_fetcher_if.master bus
);

  localparam int unsigned PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned IdxW = (Resolution > 1) ? $clog2(Resolution) : 1;
  localparam logic [IdxW-1:0] LastIdx  = IdxW'(Resolution - 1);
  localparam logic [CntW-1:0] DepthCnt = CntW'(FifoDepth);

  typedef enum logic [2:0] {StIdle, StReadR, StReadG, StReadB, StPush} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] idx_q;
  logic [19:0]     base_q;      // byte address of the current pixel, 3*idx
  logic [1:0]      sel_q;
  logic [7:0]      r_q, g_q;

  logic [23:0]     fifo_q [FifoDepth];
  logic [PtrW-1:0] wr_q, rd_q;
  logic [CntW-1:0] cnt_q;
  logic [23:0]     last_q;      // last popped pixel, shown while the FIFO is empty

  logic        mem_rd;
  logic [19:0] mem_addr;
  logic        push;
  logic        pop;
  logic        frame_done;
  logic        restart;
  logic        flush;
  logic        last_pix;
  logic [23:0] push_data;

  assign restart   = bus.frame_start;
  assign flush     = bus.frame_start && (state_q != StIdle);
  assign last_pix  = (idx_q == LastIdx);
  assign pop       = (cnt_q != '0) && bus.pixel_ready;
  assign push_data = (sel_q == 2'd3) ? 24'h000000 : {r_q, g_q, bus.mem_data};

  // Next-state and read strobe/address decode; a restart overrides everything
  always_comb begin
    state_d    = state_q;
    mem_rd     = 1'b0;
    mem_addr   = '0;
    push       = 1'b0;
    frame_done = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.frame_start) state_d = StReadR;
      end
      StReadR: begin
        // Room checked here holds at PUSH because pops can only free space
        if (cnt_q < DepthCnt) begin
          mem_rd   = 1'b1;
          mem_addr = base_q;
          state_d  = StReadG;
        end
      end
      StReadG: begin
        mem_rd   = 1'b1;
        mem_addr = base_q + 20'd1;
        state_d  = StReadB;
      end
      StReadB: begin
        mem_rd   = 1'b1;
        mem_addr = base_q + 20'd2;
        state_d  = StPush;
      end
      StPush: begin
        push = 1'b1;
        if (last_pix) begin
          frame_done = 1'b1;
          state_d    = StIdle;
        end else begin
          state_d = StReadR;
        end
      end
      default: state_d = StIdle;
    endcase
    if (flush) begin
      state_d    = StReadR;
      push       = 1'b0;
      frame_done = 1'b0;
    end
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= StIdle;
    else         state_q <= state_d;
  end

  // Pixel index, address base, latched select and partial colour capture
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      idx_q  <= '0;
      base_q <= '0;
      sel_q  <= '0;
      r_q    <= '0;
      g_q    <= '0;
    end else if (restart) begin
      idx_q  <= '0;
      base_q <= '0;
      sel_q  <= bus.image_select;
    end else begin
      if (state_q == StReadG) r_q <= bus.mem_data;
      if (state_q == StReadB) g_q <= bus.mem_data;
      if (push && !last_pix) begin
        idx_q  <= idx_q + 1'b1;
        base_q <= base_q + 20'd3;
      end
    end
  end

  // Output FIFO; depth is a power of two so pointers wrap naturally
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(FifoDepth); i++) fifo_q[i] <= '0;
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      last_q <= '0;
    end else if (flush) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) begin
        fifo_q[wr_q] <= push_data;
        wr_q         <= wr_q + 1'b1;
      end
      if (pop) begin
        last_q <= fifo_q[rd_q];
        rd_q   <= rd_q + 1'b1;
      end
      if (push && !pop)      cnt_q <= cnt_q + 1'b1;
      else if (!push && pop) cnt_q <= cnt_q - 1'b1;
    end
  end

  assign bus.mem_rd      = mem_rd;
  assign bus.mem_addr    = mem_addr;
  assign bus.mem_select  = sel_q;
  assign bus.frame_done  = frame_done;
  assign bus.pixel_valid = (cnt_q != '0);
  assign bus.pixel_rgb   = (cnt_q != '0) ? fifo_q[rd_q] : last_q;

endmodule
